led_pulse_driver: RTL



---
 rtl/led_pulse_driver_if.sv | 30 +++
 rtl/led_pulse_driver.sv | 107 ++++++++++
 2 files changed

// File: rtl/led_pulse_driver_if.sv
// rtl/led_pulse_driver_if.sv - event/status bundle for led_pulse_driver (duty present with LED_PWM_DIM_EN)
interface led_pulse_driver_if #(
  parameter int QUEUE_W = 4
);
  logic               evt_in;
  logic               clr_ovf;
`ifdef LED_PWM_DIM_EN
  logic [3:0]         duty;
`endif
  logic               led_out;
  logic               busy;
  logic [QUEUE_W-1:0] pending;
  logic               overflow;

  modport master (
`ifdef LED_PWM_DIM_EN
    output duty,
`endif
    output evt_in, clr_ovf,
    input  led_out, busy, pending, overflow
  );

  modport slave (
`ifdef LED_PWM_DIM_EN
    input  duty,
`endif
    input  evt_in, clr_ovf,
    output led_out, busy, pending, overflow
  );
endinterface

// File: rtl/led_pulse_driver.sv
// rtl/led_pulse_driver.sv - event-to-LED pulse stretcher with pending queue; LED_PWM_DIM_EN adds duty dimming
module led_pulse_driver #(
  parameter int ON_CYCLES  = 65535,
  parameter int GAP_CYCLES = 65535,
  parameter int QUEUE_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  led_pulse_driver_if.slave    bus
);
  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

  localparam logic [15:0]        ON_LAST  = 16'(ON_CYCLES - 1);
  localparam logic [15:0]        GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [QUEUE_W-1:0] PEND_MAX = '1;

  state_t             state, state_d;
  logic [15:0]        phase, phase_d;
  logic [QUEUE_W-1:0] pend, pend_d;
  logic               inc, drop;
  logic               led_d, busy_d;

`ifdef LED_PWM_DIM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst) pwm_cnt <= 4'd0;
    else     pwm_cnt <= pwm_cnt + 4'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      phase        <= 16'd0;
      pend         <= '0;
      bus.overflow <= 1'b0;
      bus.led_out  <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      state       <= state_d;
      phase       <= phase_d;
      pend        <= pend_d;
      bus.led_out <= led_d;
      bus.busy    <= busy_d;
      // A drop on the same edge as a clear must leave the flag set
      if (drop)             bus.overflow <= 1'b1;
      else if (bus.clr_ovf) bus.overflow <= 1'b0;
    end
  end

  assign bus.pending = pend;

  always_comb begin
    state_d = state;
    phase_d = phase + 16'd1;
    pend_d  = pend;
    inc     = 1'b0;
    drop    = 1'b0;
    case (state)
      S_IDLE: begin
        phase_d = 16'd0;
        if (bus.evt_in) state_d = S_ON;
      end
      S_ON: begin
        inc = bus.evt_in;
        if (phase == ON_LAST) begin
          state_d = S_GAP;
          phase_d = 16'd0;
        end
      end
      S_GAP: begin
        if (phase == GAP_LAST) begin
          phase_d = 16'd0;
          // Consuming a queued event and accepting a new one cancel out
          if (pend != '0) begin
            state_d = S_ON;
            if (!bus.evt_in) pend_d = pend - QUEUE_W'(1);
          end else if (bus.evt_in) begin
            state_d = S_ON;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          inc = bus.evt_in;
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = 16'd0;
      end
    endcase
    if (inc) begin
      if (pend == PEND_MAX) drop = 1'b1;
      else                  pend_d = pend + QUEUE_W'(1);
    end
  end

  always_comb begin
    busy_d = (state_d != S_IDLE);
`ifdef LED_PWM_DIM_EN
    led_d  = (state_d == S_ON) && (pwm_cnt < bus.duty);
`else
    led_d  = (state_d == S_ON);
`endif
  end
endmodule
